// File: rtl/bean_scorer_pkg.sv
//------------------------------------------------------------------------------
// bean_scorer_pkg
// Shared constants for the bean scorer slice: screen geometry, the tile grid
// derived from it, the tile-index formula and the scan FSM state encoding.
// No ports.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
package bean_scorer_pkg;

   localparam int WIDTH      = 640;
   localparam int HEIGHT     = 480;
   localparam int TILE_SIZE  = 20;
   localparam int TILE_COLS  = WIDTH / TILE_SIZE;    // 32
   localparam int TILE_ROWS  = HEIGHT / TILE_SIZE;   // 24
   localparam int NTILES     = TILE_COLS * TILE_ROWS; // 768

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Flat bit position of tile (row, col) in the tilemap and bean bitmaps.
   function automatic int tile_index(input int row, input int col, input int cols);
      return row * cols + col;
   endfunction

endpackage

// File: rtl/bean_scorer_if.sv
//------------------------------------------------------------------------------
// bean_scorer_if
// Request/result bundle between the game logic and the bean scorer.
//   start       : one-cycle scan request
//   tilemap     : 0 = road, 1 = wall, bit index row*COLS+col
//   beans       : 1 = bean eaten, same indexing
//   busy        : scan in progress
//   done        : one-cycle pulse when results update
//   score       : points earned (saturating)
//   remaining   : uneaten beans on road tiles
//   level_clear : all road beans eaten and at least one road tile exists
// Modports: master (game/control side), slave (scorer side).
//------------------------------------------------------------------------------
`timescale 1ns/1ps
interface bean_scorer_if
   import bean_scorer_pkg::*;
#(
   parameter int COLS    = TILE_COLS,
   parameter int ROWS    = TILE_ROWS,
   parameter int SCORE_W = 16
);
   localparam int NT    = COLS * ROWS;
   localparam int CNT_W = $clog2(NT + 1);

   logic             start;
   logic [NT-1:0]    tilemap;
   logic [NT-1:0]    beans;
   logic             busy;
   logic             done;
   logic [SCORE_W-1:0] score;
   logic [CNT_W-1:0] remaining;
   logic             level_clear;

   modport master (
      output start, tilemap, beans,
      input  busy, done, score, remaining, level_clear
   );

   modport slave (
      input  start, tilemap, beans,
      output busy, done, score, remaining, level_clear
   );

endinterface

// File: rtl/bean_scorer_row_popcount.sv
//------------------------------------------------------------------------------
// row_popcount
// Combinational population count of one tile row.
//   i_vec   : COLS-bit row vector
//   o_count : number of set bits (6 bits for 32 columns)
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module row_popcount #(
   parameter int COLS  = 32,
   parameter int CNT_W = $clog2(COLS + 1)
) (
   input  logic [COLS-1:0]  i_vec,
   output logic [CNT_W-1:0] o_count
);

   always_comb begin
      // NOTE: a combinational block assigns its output before any branch or
      // loop touches it, so no path leaves it unassigned and no latch appears.
      o_count = '0;
      for (int i = 0; i < COLS; i++) begin
         // NOTE: blocking '=' here so each iteration sees the running sum.
         o_count = o_count + CNT_W'(i_vec[i]);
      end
   end

endmodule

// File: rtl/bean_scorer.sv
//------------------------------------------------------------------------------
// bean_scorer
// Snapshots the tilemap and eaten-bean bitmap on a start request, scans one
// tile row per clock, and publishes score, beans remaining and a level-clear
// flag in a single DONE cycle, pulsing done as the results land.
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : bean_scorer_if.slave (start/tilemap/beans in, results out)
// Optional build macro: BEAN_SCORER_BONUS_EN adds LEVEL_BONUS to the score
// whenever a scan finds the level clear, and records that it was awarded.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module bean_scorer
   import bean_scorer_pkg::*;
#(
   parameter int COLS        = TILE_COLS,
   parameter int ROWS        = TILE_ROWS,
   parameter int BEAN_POINTS = 10,
   parameter int SCORE_W     = 16,
   parameter int LEVEL_BONUS = 500
) (
   input  logic clk,
   input  logic reset,
   bean_scorer_if.slave bus
);

   localparam int NT      = COLS * ROWS;
   localparam int ACC_W   = $clog2(NT + 1);
   localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int RCNT_W  = $clog2(COLS + 1);
   localparam int PROD_W  = ACC_W + $clog2(BEAN_POINTS + 1);
   localparam int BONUS_W = $clog2(LEVEL_BONUS + 1);
   // One bit of headroom over the wider addend so product + bonus never wraps.
   localparam int SUM_W   = ((PROD_W > BONUS_W) ? PROD_W : BONUS_W) + 1;
   localparam int CMP_W   = (SUM_W > SCORE_W) ? SUM_W : SCORE_W;
   localparam logic [CMP_W-1:0] SCORE_MAX = CMP_W'({SCORE_W{1'b1}});

   state_t             r_state;
   logic [NT-1:0]      r_tilemap;
   logic [NT-1:0]      r_beans;
   logic [ROW_W-1:0]   r_row;
   logic [ACC_W-1:0]   r_eaten;
   logic [ACC_W-1:0]   r_total;
   logic               r_busy;
   logic               r_done;
   logic [SCORE_W-1:0] r_score;
   logic [ACC_W-1:0]   r_remaining;
   logic               r_level_clear;

   logic [COLS-1:0]    w_road_row;
   logic [COLS-1:0]    w_eaten_row;
   logic [RCNT_W-1:0]  w_road_cnt;
   logic [RCNT_W-1:0]  w_eaten_cnt;
   logic               w_clear;
   logic               w_add_bonus;
   logic [PROD_W-1:0]  w_product;
   logic [CMP_W-1:0]   w_sum;
   logic [SCORE_W-1:0] w_score_next;

   // Beans recorded on wall tiles are masked off by the road mask.
   assign w_road_row  = ~r_tilemap[tile_index(int'(r_row), 0, COLS) +: COLS];
   assign w_eaten_row = w_road_row & r_beans[tile_index(int'(r_row), 0, COLS) +: COLS];

   row_popcount #(.COLS(COLS), .CNT_W(RCNT_W)) u_road_pop (
      .i_vec   (w_road_row),
      .o_count (w_road_cnt)
   );

   row_popcount #(.COLS(COLS), .CNT_W(RCNT_W)) u_eaten_pop (
      .i_vec   (w_eaten_row),
      .o_count (w_eaten_cnt)
   );

   assign w_clear = (r_total != '0) && (r_eaten == r_total);

`ifdef BEAN_SCORER_BONUS_EN
   logic r_bonus_given;

   // Sticky record that the clear bonus has been awarded; only reset clears it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_bonus_given <= 1'b0;
      end else begin
         r_bonus_given <= r_bonus_given | ((r_state == ST_DONE) && w_clear);
      end
   end

   // The bonus is a fixed addend on top of eaten*BEAN_POINTS, recomputed each
   // scan, so a level that stays clear keeps it without ever doubling it.
   assign w_add_bonus = w_clear;
`else
   assign w_add_bonus = 1'b0;
`endif

   // Full-width product and sum, then clamp to the score width.
   always_comb begin
      w_product    = PROD_W'(r_eaten) * PROD_W'(BEAN_POINTS);
      w_sum        = CMP_W'(w_product) + (w_add_bonus ? CMP_W'(LEVEL_BONUS) : CMP_W'(0));
      w_score_next = (w_sum > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : SCORE_W'(w_sum);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_IDLE;
         // NOTE: the wide snapshot registers are ordinary flops, not a RAM,
         // so they take a reset value like every other piece of state.
         r_tilemap     <= '0;
         r_beans       <= '0;
         r_row         <= '0;
         r_eaten       <= '0;
         r_total       <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_score       <= '0;
         r_remaining   <= '0;
         r_level_clear <= 1'b0;
      end else begin
         // NOTE: non-blocking '<=' for all clocked state so every register
         // samples pre-edge values regardless of statement order.
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_tilemap <= bus.tilemap;
                  r_beans   <= bus.beans;
                  r_row     <= '0;
                  r_eaten   <= '0;
                  r_total   <= '0;
                  r_busy    <= 1'b1;
                  r_state   <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               r_eaten <= r_eaten + ACC_W'(w_eaten_cnt);
               r_total <= r_total + ACC_W'(w_road_cnt);
               r_row   <= r_row + 1'b1;
               if (r_row == ROW_W'(ROWS - 1)) begin
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               // start is deliberately not looked at here.
               r_remaining   <= r_total - r_eaten;
               r_score       <= w_score_next;
               r_level_clear <= w_clear;
               r_done        <= 1'b1;
               r_busy        <= 1'b0;
               r_state       <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.score       = r_score;
   assign bus.remaining   = r_remaining;
   assign bus.level_clear = r_level_clear;

endmodule

// File: doc/bean_scorer.md
# bean_scorer

Reads the eaten-bean bitmap written by the player movement logic and turns it into game state: total score, beans remaining, and a level-clear flag. On each `start` pulse it snapshots the tilemap and bean bitmap, then scans one 32-tile row per clock. At the end of the scan it publishes the results. It sits between the player block and the HUD/game-control logic and is typically started once per video frame.

## Interface
Parameters:
- `COLS`, 32: tiles per row (640/20)
- `ROWS`, 24: tile rows (480/20)
- `BEAN_POINTS`, 10: points per eaten bean
- `SCORE_W`, 16: score width
- `LEVEL_BONUS`, 500: one-time clear bonus (used only with `BEAN_SCORER_BONUS_EN`)

Ports:
- `clk`, in, 1: system clock
- `reset`, in, 1: asynchronous, active-low reset
- `start`, in, 1: one-cycle request to begin a scan
- `tilemap`, in, COLS*ROWS: 0 = road (bean-bearing tile), 1 = wall; bit index = row*COLS+col
- `beans`, in, COLS*ROWS: 1 = bean eaten; same indexing
- `busy`, out, 1: scan in progress
- `done`, out, 1: one-cycle pulse when results update
- `score`, out, SCORE_W: points earned
- `remaining`, out, $clog2(COLS*ROWS+1): uneaten beans on road tiles
- `level_clear`, out, 1: high while `remaining`==0 and the map has ≥1 road tile

## Operation
- FSM states: IDLE, SCAN, DONE.
- **IDLE**: when `start`=1, the block snapshots `tilemap` and `beans` into internal registers, clears the row index and both accumulators, and goes to SCAN.
- **SCAN**: each cycle, for row r:
  - road = ~tilemap_row
  - eaten += popcount(road & beans_row)
  - total += popcount(road)
  - r increments; after r = ROWS-1 the FSM goes to DONE.
- Eaten bits on wall tiles are masked and never counted.
- **DONE**, one cycle:
  - `remaining` ← total − eaten
  - `score` ← eaten*BEAN_POINTS, saturating at 2^SCORE_W−1
  - `level_clear` ← (total≠0 && eaten==total)
  - `done` pulses; the FSM returns to IDLE.
- `start` while `busy` is ignored; no queuing.
- `start` asserted in the DONE cycle is ignored. It is accepted from the next IDLE cycle.
- Inputs may change freely after the `start` cycle; only the snapshot is used.
- Outputs hold their previous values throughout a scan.
- Reset values:
  - state IDLE, `busy`=0, `done`=0, `score`=0, `remaining`=0, `level_clear`=0
  - snapshot, accumulators and row index = 0
- Reset mid-scan aborts immediately; outputs return to reset values and no `done` is produced.

## Timing
- `start` is sampled at edge 0. SCAN covers rows 0..ROWS-1 on edges 1..ROWS. The DONE edge, ROWS+1, registers the results.
- `done` is high during the cycle after edge ROWS+1. The new outputs are valid in that same cycle.
- Latency from `start` to `done`: ROWS+2 cycles (26 by default). Maximum start rate: one per ROWS+2 cycles.
- `busy` is high from the cycle after the start edge through the cycle before `done`.
- Accumulators are $clog2(COLS*ROWS+1) bits (10) and cannot overflow.
- The score product is computed at full width (accumulator width + $clog2(BEAN_POINTS+1)) before saturation.

## Configuration
- `BEAN_SCORER_BONUS_EN` defined:
  - An internal `bonus_given` flag is added, reset to 0.
  - On the first DONE in which `level_clear` becomes 1, `LEVEL_BONUS` is added to `score`, saturating, and `bonus_given` sets.
  - Later scans still add the bonus while `bonus_given`=1 and the level stays clear. The bonus is never doubled.
  - The flag clears only on reset.
- Undefined: `score` is exactly eaten*BEAN_POINTS (saturating), and `LEVEL_BONUS` is unused.

## Structure
- Shared package/header: WIDTH=640, HEIGHT=480, TILE_SIZE=20, derived COLS/ROWS/NTILES, the tile-index formula, and the FSM state encoding.
- One sub-module, `row_popcount`: combinational popcount of a COLS-bit vector, 6-bit output, instantiated twice (road, eaten).

## Test plan
- Tilemap all 1 (walls), `beans` all 1, start → after 26 cycles `done`; `remaining`=0, `score`=0, `level_clear`=0.
- Tilemap all 0 (768 road), `beans`=0, start → `remaining`=768, `score`=0, `level_clear`=0.
- Road = row 3 only (32 tiles), `beans` bits 96..100 set plus bit 0 on a wall → `remaining`=27, `score`=50.
- Same map with all row-3 beans set → `level_clear`=1, `score`=320. With `BEAN_SCORER_BONUS_EN`: `score`=820, and it is still 820 after a second scan.
- All 768 road tiles eaten, SCORE_W=12 → `score` saturates at 4095.
- Assert `start` at cycle 5 of a scan, then drop `reset` at cycle 10 of a new scan → first start ignored; after reset all outputs are 0 and no `done` pulse occurs.
